// File: rtl/mask_pkg.sv
// Shared widths, FSM state type and accumulator record for the mask centroid block.
package mask_pkg;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 20;
    localparam int SUM_W   = 30;

    localparam logic [COORD_W-1:0] COORD_MAX = 10'd1023;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [2:0] {IDLE, EMPTY, DIV_X, DIV_Y, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]   cnt;
        logic [SUM_W-1:0]   sx;
        logic [SUM_W-1:0]   sy;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } acc_t;

    localparam acc_t ACC_INIT = '{cnt: '0, sx: '0, sy: '0,
                                  xmin: COORD_MAX, xmax: '0,
                                  ymin: COORD_MAX, ymax: '0};
endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per enabled cycle; done pulses 30 cycles after start.
// The first quotient bit is produced on the start cycle itself.
module serial_divider
    import mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               start,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [CNT_W-1:0]   divisor,
    output logic [COORD_W-1:0] quotient,
    output logic               done
);
    logic [CNT_W-1:0] rem, dvs, rem_in, dvs_in, rem_nxt;
    logic [SUM_W-1:0] quo, quo_in;
    logic [CNT_W:0]   trial;
    logic             qbit, busy;
    logic [4:0]       cnt;

    always_comb begin
        rem_in  = start ? '0 : rem;
        quo_in  = start ? dividend : quo;
        dvs_in  = start ? divisor : dvs;
        trial   = {rem_in, quo_in[SUM_W-1]};
        qbit    = 1'b0;
        rem_nxt = trial[CNT_W-1:0];
        if (trial >= {1'b0, dvs_in}) begin
            qbit    = 1'b1;
            rem_nxt = CNT_W'(trial - {1'b0, dvs_in});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            if (start) begin
                rem  <= rem_nxt;
                quo  <= {quo_in[SUM_W-2:0], qbit};
                dvs  <= divisor;
                cnt  <= 5'(SUM_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= rem_nxt;
                quo <= {quo_in[SUM_W-2:0], qbit};
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Mean coordinate never exceeds COORD_MAX, so the low bits hold the whole quotient.
    assign quotient = quo[COORD_W-1:0];
endmodule

// File: rtl/mask_centroid.sv
// Per-frame mask pixel count, coordinate sums and bounding box; centroid computed at vsync rise.
// Results appear 63 enabled cycles after the boundary (2 for an empty frame) with a valid pulse.
module mask_centroid
    import mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               mask,
    input  logic               in_de,
    input  logic               in_vsync,
    input  logic               in_hsync,
    output logic [COORD_W-1:0] x_center,
    output logic [COORD_W-1:0] y_center,
    output logic [CNT_W-1:0]   pix_count,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic               found,
    output logic               result_valid,
    output logic               overrun
);
    logic               vsync_d, de_d, boundary, pix;
    logic [COORD_W-1:0] x, y, qx, div_q;
    acc_t               acc, acc_nxt, snap;
    state_t             state;
    logic               div_wait, div_start, div_done;

    assign boundary  = in_vsync & ~vsync_d;
    assign pix       = in_de & mask;
    assign div_start = ((state == DIV_X) || (state == DIV_Y)) && !div_wait;

    // Includes the pixel of the current cycle so a boundary snapshot keeps it in the old frame.
    always_comb begin
        acc_nxt = acc;
        if (pix) begin
            if (acc.cnt != CNT_MAX) acc_nxt.cnt = acc.cnt + CNT_W'(1);
            acc_nxt.sx = acc.sx + SUM_W'(x);
            acc_nxt.sy = acc.sy + SUM_W'(y);
            if (x < acc.xmin) acc_nxt.xmin = x;
            if (x > acc.xmax) acc_nxt.xmax = x;
            if (y < acc.ymin) acc_nxt.ymin = y;
            if (y > acc.ymax) acc_nxt.ymax = y;
        end
    end

    serial_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .start    (div_start),
        .dividend ((state == DIV_Y) ? snap.sy : snap.sx),
        .divisor  (snap.cnt),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d      <= 1'b0;
            de_d         <= 1'b0;
            x            <= '0;
            y            <= '0;
            acc          <= ACC_INIT;
            snap         <= ACC_INIT;
            state        <= IDLE;
            div_wait     <= 1'b0;
            qx           <= '0;
            x_center     <= '0;
            y_center     <= '0;
            pix_count    <= '0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (ce) begin
            vsync_d      <= in_vsync;
            de_d         <= in_de;
            result_valid <= 1'b0;
            overrun      <= 1'b0;

            if (boundary) begin
                x <= '0;
                y <= '0;
            end else if (de_d && !in_de) begin
                x <= '0;
                if (y != COORD_MAX) y <= y + COORD_W'(1);
            end else if (in_de) begin
                if (x != COORD_MAX) x <= x + COORD_W'(1);
            end else if (in_hsync) begin
                x <= '0;  // x is already zero in blanking; realigns defensively
            end

            acc <= boundary ? ACC_INIT : acc_nxt;

            if (div_start) div_wait <= 1'b1;
            else if (div_done) div_wait <= 1'b0;

            if (boundary && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: if (boundary) begin
                    snap  <= acc_nxt;
                    state <= (acc_nxt.cnt != '0) ? DIV_X : EMPTY;
                end
                EMPTY: begin
                    x_center     <= '0;
                    y_center     <= '0;
                    pix_count    <= '0;
                    x_min        <= '0;
                    x_max        <= '0;
                    y_min        <= '0;
                    y_max        <= '0;
                    found        <= 1'b0;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                DIV_X: if (div_done) begin
                    qx    <= div_q;
                    state <= DIV_Y;
                end
                DIV_Y: if (div_done) begin
                    x_center     <= qx;
                    y_center     <= div_q;
                    pix_count    <= snap.cnt;
                    x_min        <= snap.xmin;
                    x_max        <= snap.xmax;
                    y_min        <= snap.ymin;
                    y_max        <= snap.ymax;
                    found        <= 1'b1;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mask_centroid.sv
// Directed frames through mask_centroid; expected results queued at each vsync rise and checked on result_valid.
module tb_mask_centroid;
    localparam logic [9:0] H_SIZE = 10'd83;
    localparam int         V_SIZE = 64;

    typedef struct {
        int          due;
        logic [19:0] cnt;
        logic [9:0]  xc, yc, xmin, xmax, ymin, ymax;
        logic        found;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b1;
    logic        mask = 1'b0, in_de = 1'b0, in_vsync = 1'b0, in_hsync = 1'b0;
    logic [9:0]  x_center, y_center, x_min, x_max, y_min, y_max;
    logic [19:0] pix_count;
    logic        found, result_valid, overrun;

    int   cyc = 0;
    int   n_pass = 0, n_total = 0, n_fail = 0;
    int   ovr_cnt = 0, ovr_cyc = -1;
    int   t0, t_ovr;
    exp_t sb[$];

    mask_centroid dut (
        .clk(clk), .rst(rst), .ce(ce), .mask(mask), .in_de(in_de),
        .in_vsync(in_vsync), .in_hsync(in_hsync),
        .x_center(x_center), .y_center(y_center), .pix_count(pix_count),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .found(found), .result_valid(result_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pixel(input int kind, input int px, input int py);
        case (kind)
            1:       return (px == 5 && py == 3);
            2:       return (px >= 10 && px <= 19 && py >= 20 && py <= 29);
            3:       return (px == 0 && py == 0) || (px == 82 && py == 63);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_frame(input int kind);
        for (int l = 0; l < V_SIZE; l++) begin
            for (int p = 0; p < int'(H_SIZE); p++) begin
                in_de = 1'b1;
                mask  = pixel(kind, p, l);
                tick();
            end
            in_de = 1'b0;
            mask  = 1'b0;
            in_hsync = 1'b1;
            repeat (2) tick();
            in_hsync = 1'b0;
            repeat (2) tick();
        end
    endtask

    // Expected values derived by hand from the pixel patterns above.
    task automatic push_exp(input int kind, input int due);
        exp_t e;
        e.due = due;
        case (kind)
            1: begin e.cnt = 20'd1;   e.xc = 10'd5;  e.yc = 10'd3;  e.xmin = 10'd5;  e.xmax = 10'd5;
                     e.ymin = 10'd3;  e.ymax = 10'd3;  e.found = 1'b1; end
            2: begin e.cnt = 20'd100; e.xc = 10'd14; e.yc = 10'd24; e.xmin = 10'd10; e.xmax = 10'd19;
                     e.ymin = 10'd20; e.ymax = 10'd29; e.found = 1'b1; end
            3: begin e.cnt = 20'd2;   e.xc = 10'd41; e.yc = 10'd31; e.xmin = 10'd0;  e.xmax = 10'd82;
                     e.ymin = 10'd0;  e.ymax = 10'd63; e.found = 1'b1; end
            default: begin e.cnt = '0; e.xc = '0; e.yc = '0; e.xmin = '0; e.xmax = '0;
                     e.ymin = '0; e.ymax = '0; e.found = 1'b0; end
        endcase
        sb.push_back(e);
    endtask

    task automatic vsync_rise(input int kind, input int lat);
        in_vsync = 1'b1;
        t0 = cyc;
        push_exp(kind, t0 + lat);
        tick();
        in_vsync = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_count"}, pix_count, 0);
        check({tag, "_center"}, {x_center, y_center}, 0);
        check({tag, "_bbox"}, {x_min, x_max, y_min, y_max}, 0);
        check({tag, "_flags"}, {found, result_valid, overrun}, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (overrun) begin
                    ovr_cnt++;
                    ovr_cyc = cyc;
                end
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_result_valid", result_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("result_cycle", cyc, e.due);
                        check("pix_count", pix_count, e.cnt);
                        check("x_center", x_center, e.xc);
                        check("y_center", y_center, e.yc);
                        check("bbox", {x_min, x_max, y_min, y_max}, {e.xmin, e.xmax, e.ymin, e.ymax});
                        check("found", found, e.found);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].due) begin
                    check("result_timeout", cyc, sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("after_reset");

        // Single pixel at (5,3)
        drive_frame(1);
        vsync_rise(1, 63);
        repeat (70) tick();
        check("hold_x_center", x_center, 5);
        check("hold_found", found, 1);

        // 10x10 rectangle
        drive_frame(2);
        vsync_rise(2, 63);
        repeat (70) tick();

        // Empty frame
        drive_frame(0);
        vsync_rise(0, 2);
        repeat (10) tick();
        check("empty_pix_count_hold", pix_count, 0);

        // Clock enable stall during the x division
        drive_frame(1);
        vsync_rise(1, 70);
        while (cyc < t0 + 10) tick();
        ce = 1'b0;
        repeat (7) tick();
        ce = 1'b1;
        repeat (70) tick();

        // Second boundary while busy, then a fresh frame accumulated from zero
        drive_frame(1);
        vsync_rise(1, 63);
        t_ovr = t0;
        while (cyc < t_ovr + 20) tick();
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
        drive_frame(3);
        vsync_rise(3, 63);
        repeat (70) tick();
        check("overrun_pulses", ovr_cnt, 1);
        check("overrun_cycle", ovr_cyc, t_ovr + 21);

        // Reset in the middle of the division
        drive_frame(1);
        vsync_rise(1, 63);
        while (cyc < t0 + 40) tick();
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        check_zero("mid_reset");
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("no_result_after_reset", result_valid, 0);
        drive_frame(2);
        vsync_rise(2, 63);
        repeat (70) tick();

        check("results_pending", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
